// File: rtl/multicycle_control.sv
// Multicycle control FSM for the CHARIS datapath. It sequences one instruction
// at a time through fetch, decode, execute, memory and writeback.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        Mem_ack,
  output logic        IR_LdEn,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic [1:0]  ImmExt,
  output logic        ALU_bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_RdEn,
  output logic        Mem_WrEn,
  output logic        err
);
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [3:0] TO_LAST  = 4'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_ILLEGAL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [5:0] opc, fn;
  logic       is_r, is_ialu, is_load, is_store, is_br, r_ok, mem_to, b_taken;
  logic [3:0] i_func;
  logic [1:0] i_ext;
  logic       unused_ir;

  assign opc       = ir_q[31:26];
  assign fn        = ir_q[5:0];
  assign unused_ir = ^ir_q[25:6];
  assign is_r      = (opc == OP_RTYPE);
  assign is_ialu   = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI) ||
                     (opc == OP_LI)   || (opc == OP_LUI);
  assign is_load   = (opc == OP_LW) || (opc == OP_LB);
  assign is_store  = (opc == OP_SW) || (opc == OP_SB);
  assign is_br     = (opc == OP_B) || (opc == OP_BEQ) || (opc == OP_BNE);
  assign mem_to    = (cnt_q == TO_LAST);
  assign b_taken   = (opc == OP_B) || ((opc == OP_BEQ) && zero) || ((opc == OP_BNE) && !zero);
  assign ir_d      = (state_q == S_FETCH) ? instr : ir_q;

  // Legal R-type funcs all map onto the ALU code carried in func[3:0].
  always_comb begin
    r_ok = 1'b0;
    case (fn)
      6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
      6'b111000, 6'b111001, 6'b111010, 6'b111100, 6'b111101: r_ok = 1'b1;
      default: r_ok = 1'b0;
    endcase
  end

  // Immediate ALU ops, loads and stores; li relies on rs=0 to pass the immediate.
  always_comb begin
    i_func = 4'b0000;
    i_ext  = 2'b00;
    case (opc)
      OP_ANDI: begin i_func = 4'b0010; i_ext = 2'b01; end
      OP_ORI:  begin i_func = 4'b0011; i_ext = 2'b01; end
      OP_LUI:  i_ext = 2'b10;
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    err_d         = err_q;
    IR_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ImmExt        = 2'b00;
    ALU_bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Mem_RdEn      = 1'b0;
    Mem_WrEn      = 1'b0;
    case (state_q)
      S_FETCH: begin
        IR_LdEn = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        RF_B_sel = (opc == OP_BEQ) || (opc == OP_BNE) || is_store;
        if (is_r || is_ialu || is_load || is_store) state_d = S_EXEC;
        else if (is_br)                             state_d = S_BRANCH;
        else begin
          state_d = S_ILLEGAL;
          err_d   = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          ALU_func = r_ok ? fn[3:0] : 4'b0000;
          if (r_ok) state_d = S_WB_ALU;
          else begin
            state_d = S_ILLEGAL;
            err_d   = 1'b1;
          end
        end else begin
          ALU_bin_sel = 1'b1;
          ALU_func    = i_func;
          ImmExt      = i_ext;
          state_d     = is_load ? S_MEM_RD : (is_store ? S_MEM_WR : S_WB_ALU);
        end
      end
      S_MEM_RD: begin
        Mem_RdEn = 1'b1;
        if (Mem_ack) state_d = S_WB_MEM;
        else if (mem_to) begin
          PC_LdEn = 1'b1;
          err_d   = 1'b1;
          state_d = S_FETCH;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_MEM_WR: begin
        Mem_WrEn = 1'b1;
        if (Mem_ack || mem_to) begin
          PC_LdEn = 1'b1;
          state_d = S_FETCH;
          if (!Mem_ack) err_d = 1'b1;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_WB_ALU: begin
        RF_WrEn = 1'b1;
        PC_LdEn = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_MEM: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b1;
        PC_LdEn       = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ALU_func = 4'b0001;
        ImmExt   = 2'b11;
        PC_LdEn  = 1'b1;
        PC_sel   = b_taken;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: begin
        PC_LdEn = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset blanks every strobe in the very cycle it is raised.
    if (Reset) begin
      IR_LdEn       = 1'b0;
      PC_sel        = 1'b0;
      PC_LdEn       = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ImmExt        = 2'b00;
      ALU_bin_sel   = 1'b0;
      ALU_func      = 4'b0000;
      Mem_RdEn      = 1'b0;
      Mem_WrEn      = 1'b0;
    end
  end

  assign err = err_q & ~Reset;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule
